// File: rtl/eprom_ctrl.sv
// eprom_ctrl: clocked EPROM with registered read, bit-clearing program and erase sweep.
// Define EPROM_WRITE_PROTECT_EN to add a wp input that rejects program/erase requests.
module eprom_ctrl #(
  parameter int    DATA_W      = 8,
  parameter int    ADDR_W      = 3,
  parameter int    PROG_CYCLES = 4,
  parameter string INIT_FILE   = "memory.list"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              erase,
`ifdef EPROM_WRITE_PROTECT_EN
  input  logic              wp,
`endif
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              prog_err
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CNT_MAX = (PROG_CYCLES > DEPTH) ? PROG_CYCLES : DEPTH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PROG_LAST  = CNT_W'(PROG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(DEPTH - 1);
  localparam int DEF_N = 8;
  localparam int DEF_IMG [DEF_N] = '{22, 15, 13, 17, 18, 19, 0, 21};

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;
  typedef enum logic [1:0] {IDLE, PROG, ERASE} state_e;

  function automatic mem_t load_image();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = '1;
      if (INIT_FILE != "" && i < DEF_N) m[i] = DATA_W'(DEF_IMG[i]);
    end
    return m;
  endfunction

  // Storage has no reset path: contents survive reset by design.
  mem_t mem_q = load_image();
  mem_t mem_d;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [DATA_W-1:0] pd_q, pd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              rej_q, rej_d;
  logic              wp_i;
  logic              commit;
  logic              bad_bits;

`ifdef EPROM_WRITE_PROTECT_EN
  assign wp_i = wp;
`else
  assign wp_i = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pa_d     = pa_q;
    pd_d     = pd_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rej_d    = 1'b0;
    mem_d    = mem_q;
    commit   = 1'b0;
    bad_bits = |(~mem_q[pa_q] & pd_q);
    unique case (state_q)
      IDLE: begin
        if (cs) begin
          if ((erase | wr_en) & wp_i) begin
            rej_d = 1'b1;
          end else if (erase) begin
            state_d = ERASE;
            cnt_d   = '0;
          end else if (wr_en) begin
            state_d = PROG;
            cnt_d   = '0;
            pa_d    = addr;
            pd_d    = wdata;
          end else if (rd_en) begin
            rdata_d  = mem_q[addr];
            rvalid_d = 1'b1;
          end
        end
      end
      PROG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PROG_LAST) begin
          commit      = 1'b1;
          mem_d[pa_q] = mem_q[pa_q] & pd_q;
          state_d     = IDLE;
          cnt_d       = '0;
        end
      end
      ERASE: begin
        mem_d[cnt_q[ADDR_W-1:0]] = '1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ERASE_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pa_q     <= '0;
      pd_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pa_q     <= pa_d;
      pd_q     <= pd_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rej_q    <= rej_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign busy     = (state_q != IDLE);
  assign prog_err = rej_q | (commit & bad_bits);

endmodule

// File: tb/tb_eprom_ctrl.sv
// tb_eprom_ctrl: directed self-checking bench for eprom_ctrl.
// Starts from an all-ones array and programs the reference image itself.
module tb_eprom_ctrl;

  localparam int PC = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       rd_en;
  logic       wr_en;
  logic       erase;
  logic       wp;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       prog_err;

  logic [7:0] img [DEPTH] = '{8'd22, 8'd15, 8'd13, 8'd17,
                              8'd18, 8'd19, 8'd0, 8'd21};

  int total = 0;
  int passed = 0;

  eprom_ctrl #(
    .DATA_W(8),
    .ADDR_W(3),
    .PROG_CYCLES(PC),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .erase(erase),
`ifdef EPROM_WRITE_PROTECT_EN
    .wp(wp),
`endif
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .rvalid(rvalid),
    .busy(busy),
    .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] expv);
    cs = 1'b1;
    rd_en = 1'b1;
    addr = a;
    tick();
    rd_en = 1'b0;
    chk("rd_valid", 32'(rvalid), 32'd1);
    chk("rd_data", 32'(rdata), 32'(expv));
  endtask

  task automatic prog(input logic [2:0] a, input logic [7:0] d,
                      input int errs);
    int nb;
    int ne;
    cs = 1'b1;
    wr_en = 1'b1;
    addr = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
    nb = 0;
    ne = 0;
    for (int i = 0; i < PC + 2; i++) begin
      nb += int'(busy);
      ne += int'(prog_err);
      tick();
    end
    chk("prog_busy_cycles", 32'(nb), 32'(PC));
    chk("prog_err_pulses", 32'(ne), 32'(errs));
  endtask

  task automatic load_image();
    for (int i = 0; i < DEPTH; i++) prog(3'(i), img[i], 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prog_err", 32'(prog_err), 32'd0);
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    cs = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    erase = 1'b0;
    wp = 1'b0;
    addr = '0;
    wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outs();

    load_image();
    for (int i = 0; i < DEPTH; i++) rd(3'(i), img[i]);
    tick();
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("rdata_hold", 32'(rdata), 32'd21);

    prog(3'd2, 8'b0000_1001, 0);
    rd(3'd2, 8'h09);
    prog(3'd2, 8'hFF, 1);
    rd(3'd2, 8'h09);

    cs = 1'b1;
    erase = 1'b1;
    tick();
    erase = 1'b0;
    nb = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      nb += int'(busy);
      tick();
    end
    chk("erase_busy_cycles", 32'(nb), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) rd(3'(i), 8'hFF);

    load_image();
    erase = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr = 3'd3;
    wdata = 8'h00;
    tick();
    erase = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("prio_no_rvalid", 32'(rvalid), 32'd0);
    chk("prio_busy", 32'(busy), 32'd1);
    nb = int'(busy);
    rd_en = 1'b1;
    addr = 3'd0;
    tick();
    rd_en = 1'b0;
    chk("busy_read_ignored", 32'(rvalid), 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      nb += int'(busy);
      tick();
    end
    chk("prio_erase_busy", 32'(nb), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) rd(3'(i), 8'hFF);

    load_image();

`ifdef EPROM_WRITE_PROTECT_EN
    wp = 1'b1;
    wr_en = 1'b1;
    addr = 3'd0;
    wdata = 8'h00;
    tick();
    wr_en = 1'b0;
    chk("wp_err", 32'(prog_err), 32'd1);
    chk("wp_busy", 32'(busy), 32'd0);
    tick();
    chk("wp_err_drop", 32'(prog_err), 32'd0);
    chk("wp_busy_after", 32'(busy), 32'd0);
    wp = 1'b0;
    rd(3'd0, 8'd22);
`endif

    wr_en = 1'b1;
    addr = 3'd5;
    wdata = 8'h00;
    tick();
    wr_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outs();
    tick();
    chk("prog_abort_no_err", 32'(prog_err), 32'd0);
    rd(3'd5, 8'd19);

    erase = 1'b1;
    tick();
    erase = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outs();
    for (int i = 0; i < 3; i++) rd(3'(i), 8'hFF);
    for (int i = 3; i < DEPTH; i++) rd(3'(i), img[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
